// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module : slc3_mem_pkg
// Brief  : Shared types and constants for the SLC-3 memory access unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package slc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_reg16.sv
// ============================================================================
// Module : reg_16
// Brief  : Load-enabled register with asynchronous active-low clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_16 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module : mem_access_unit
// Brief  : MAR/MDR owner and SRAM read/write cycle sequencer with wait states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
  import slc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic [DATA_W-1:0] BUS,
  input  logic              Mem_req,
  input  logic              Mem_rw,
  output logic              Mem_ready,
  output logic              Busy,
  output logic [ADDR_W-1:0] MAR_data,
  output logic [DATA_W-1:0] MDR_data,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic [DATA_W-1:0] Data_to_SRAM,
  output logic              CE_N,
  output logic              OE_N,
  output logic              WE_N
);

  localparam int               CNT_W      = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t       r_state;
  mem_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rw;
  logic             w_cnt_zero;
  logic             w_idle;
  logic             w_ld_mar;
  logic             w_ld_mdr;
  logic             w_mdr_rd;
  logic [DATA_W-1:0] w_mdr_d;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_idle     = (r_state == IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (Mem_req) w_next = SETUP;
      SETUP:   w_next = WAIT;
      WAIT:    if (w_cnt_zero) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobes decode only registered state so no input reaches the SRAM pins.
  always_comb begin
    CE_N      = 1'b1;
    OE_N      = 1'b1;
    WE_N      = 1'b1;
    Mem_ready = 1'b0;
    Busy      = 1'b1;
    case (r_state)
      IDLE:  Busy = 1'b0;
      SETUP: begin
        CE_N = 1'b0;
        OE_N = (r_rw == MEM_READ) ? 1'b0 : 1'b1;
      end
      WAIT: begin
        CE_N = 1'b0;
        OE_N = (r_rw == MEM_READ)  ? 1'b0 : 1'b1;
        WE_N = (r_rw == MEM_WRITE) ? 1'b0 : 1'b1;
      end
      DONE:    Mem_ready = 1'b1;
      default: Busy = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
      r_rw  <= MEM_READ;
    end else begin
      if (w_idle && Mem_req) begin
        r_rw <= Mem_rw;
      end
      if (r_state == SETUP) begin
        r_cnt <= C_CNT_LOAD;
      end else if ((r_state == WAIT) && !w_cnt_zero) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // MDR takes SRAM data on the final wait edge of a read, otherwise the bus.
  assign w_mdr_rd = (r_state == WAIT) && (r_rw == MEM_READ) && w_cnt_zero;
  assign w_ld_mdr = (w_idle && LD_MDR) || w_mdr_rd;
  assign w_mdr_d  = w_mdr_rd ? Data_from_SRAM : BUS;
  assign w_ld_mar = w_idle && LD_MAR;

  reg_16 #(.W(ADDR_W)) u_mar (
    .clk   (Clk),
    .rst_n (Reset),
    .i_ld  (w_ld_mar),
    .i_d   (BUS),
    .o_q   (MAR_data)
  );

  reg_16 #(.W(DATA_W)) u_mdr (
    .clk   (Clk),
    .rst_n (Reset),
    .i_ld  (w_ld_mdr),
    .i_d   (w_mdr_d),
    .o_q   (MDR_data)
  );

  assign Data_to_SRAM = MDR_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module : tb_mem_access_unit
// Brief  : Directed self-checking bench for mem_access_unit (WAIT_CYCLES 2 and 1).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        LD_MAR, LD_MDR, Mem_req, Mem_rw;
  logic [15:0] BUS, Data_from_SRAM;

  logic        Mem_ready, Busy, CE_N, OE_N, WE_N;
  logic [15:0] MAR_data, MDR_data, Data_to_SRAM;
  logic        Mem_ready1, Busy1, CE_N1, OE_N1, WE_N1;
  logic [15:0] MAR_data1, MDR_data1, Data_to_SRAM1;

  always #5 Clk = ~Clk;

  mem_access_unit #(.WAIT_CYCLES(2), .ADDR_W(16), .DATA_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .BUS(BUS),
    .Mem_req(Mem_req), .Mem_rw(Mem_rw), .Mem_ready(Mem_ready), .Busy(Busy),
    .MAR_data(MAR_data), .MDR_data(MDR_data), .Data_from_SRAM(Data_from_SRAM),
    .Data_to_SRAM(Data_to_SRAM), .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N)
  );

  mem_access_unit #(.WAIT_CYCLES(1), .ADDR_W(16), .DATA_W(16)) dut1 (
    .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .BUS(BUS),
    .Mem_req(Mem_req), .Mem_rw(Mem_rw), .Mem_ready(Mem_ready1), .Busy(Busy1),
    .MAR_data(MAR_data1), .MDR_data(MDR_data1), .Data_from_SRAM(Data_from_SRAM),
    .Data_to_SRAM(Data_to_SRAM1), .CE_N(CE_N1), .OE_N(OE_N1), .WE_N(WE_N1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Per-access observations gathered by observe()
  int          rdy_idx, rdy_cnt, oe_cnt, we_cnt, busy_low_cnt, both_low;
  int          mar_bad, mdr_bad, dts_bad;
  logic        we_at0;
  logic [15:0] mdr_at_rdy;
  int          rdy_pos[$];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    LD_MAR = 1'b0; LD_MDR = 1'b0; Mem_req = 1'b0; Mem_rw = 1'b0;
  endtask

  // Index 0 is the sample just after the request edge.
  task automatic observe(input int n, input bit sel1,
                         input logic [15:0] exp_mar, input logic [15:0] exp_mdr);
    logic        rdy, bsy, oe, we;
    logic [15:0] mar, mdr, dts;
    rdy_idx = -1; rdy_cnt = 0; oe_cnt = 0; we_cnt = 0; busy_low_cnt = 0;
    both_low = 0; mar_bad = 0; mdr_bad = 0; dts_bad = 0; we_at0 = 1'bx;
    mdr_at_rdy = 16'hxxxx;
    rdy_pos.delete();
    for (int i = 0; i < n; i++) begin
      rdy = sel1 ? Mem_ready1   : Mem_ready;
      bsy = sel1 ? Busy1        : Busy;
      oe  = sel1 ? OE_N1        : OE_N;
      we  = sel1 ? WE_N1        : WE_N;
      mar = sel1 ? MAR_data1    : MAR_data;
      mdr = sel1 ? MDR_data1    : MDR_data;
      dts = sel1 ? Data_to_SRAM1 : Data_to_SRAM;
      if (rdy === 1'b1) begin
        if (rdy_cnt == 0) begin
          rdy_idx    = i;
          mdr_at_rdy = mdr;
        end
        rdy_cnt++;
        rdy_pos.push_back(i);
      end
      if (oe === 1'b0) oe_cnt++;
      if (we === 1'b0) we_cnt++;
      if (i == 0) we_at0 = we;
      if ((oe === 1'b0) && (we === 1'b0)) both_low++;
      if (bsy === 1'b0) busy_low_cnt++;
      if (mar !== exp_mar) mar_bad++;
      if (mdr !== exp_mdr) mdr_bad++;
      if (dts !== mdr) dts_bad++;
      tick();
    end
  endtask

  task automatic test_reset();
    int ready_seen;
    Reset = 1'b0; clear_inputs(); BUS = 16'h0; Data_from_SRAM = 16'h0;
    #1;
    n_checks++; if (CE_N !== 1'b1) $display("FAIL rst_ce: got %b want 1", CE_N); else n_pass++;
    n_checks++; if (OE_N !== 1'b1) $display("FAIL rst_oe: got %b want 1", OE_N); else n_pass++;
    n_checks++; if (WE_N !== 1'b1) $display("FAIL rst_we: got %b want 1", WE_N); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", Busy); else n_pass++;
    n_checks++; if (Mem_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", Mem_ready); else n_pass++;
    n_checks++; if (MAR_data !== 16'h0) $display("FAIL rst_mar: got %h want 0000", MAR_data); else n_pass++;
    n_checks++; if (MDR_data !== 16'h0) $display("FAIL rst_mdr: got %h want 0000", MDR_data); else n_pass++;
    tick(); tick();
    Reset = 1'b1;
    tick();
    // Write in flight, then reset asserted mid-WAIT
    BUS = 16'h0055; LD_MAR = 1'b1; LD_MDR = 1'b1; Mem_req = 1'b1; Mem_rw = 1'b1;
    tick();
    clear_inputs();
    n_checks++; if (WE_N !== 1'b1) $display("FAIL wr_setup_we: got %b want 1", WE_N); else n_pass++;
    tick();
    n_checks++; if (WE_N !== 1'b0) $display("FAIL wr_wait_we: got %b want 0", WE_N); else n_pass++;
    #2 Reset = 1'b0;
    #1;
    n_checks++; if (WE_N !== 1'b1) $display("FAIL abort_we: got %b want 1", WE_N); else n_pass++;
    n_checks++; if (CE_N !== 1'b1) $display("FAIL abort_ce: got %b want 1", CE_N); else n_pass++;
    n_checks++; if (MAR_data !== 16'h0) $display("FAIL abort_mar: got %h want 0000", MAR_data); else n_pass++;
    n_checks++; if (MDR_data !== 16'h0) $display("FAIL abort_mdr: got %h want 0000", MDR_data); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", Busy); else n_pass++;
    ready_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (Mem_ready !== 1'b0) ready_seen++;
      tick();
    end
    n_checks++; if (ready_seen != 0) $display("FAIL abort_ready: got %0d pulses want 0", ready_seen); else n_pass++;
    Reset = 1'b1;
    tick();
    n_checks++; if (Busy !== 1'b0) $display("FAIL post_rst_busy: got %b want 0", Busy); else n_pass++;
  endtask

  task automatic test_read();
    BUS = 16'h3000; Data_from_SRAM = 16'hBEEF;
    LD_MAR = 1'b1; Mem_req = 1'b1; Mem_rw = 1'b0;
    tick();
    clear_inputs();
    observe(6, 1'b0, 16'h3000, 16'h0000);
    n_checks++; if (rdy_idx != 3) $display("FAIL rd_latency: got %0d want 3", rdy_idx); else n_pass++;
    n_checks++; if (rdy_cnt != 1) $display("FAIL rd_ready_width: got %0d want 1", rdy_cnt); else n_pass++;
    n_checks++; if (oe_cnt != 3) $display("FAIL rd_oe_cycles: got %0d want 3", oe_cnt); else n_pass++;
    n_checks++; if (mdr_at_rdy !== 16'hBEEF) $display("FAIL rd_mdr: got %h want beef", mdr_at_rdy); else n_pass++;
    n_checks++; if (mar_bad != 0) $display("FAIL rd_mar: got %0d bad samples want 0", mar_bad); else n_pass++;
    n_checks++; if (we_cnt != 0) $display("FAIL rd_we: got %0d low cycles want 0", we_cnt); else n_pass++;
  endtask

  task automatic test_write();
    BUS = 16'h0042; LD_MAR = 1'b1;
    tick();
    LD_MAR = 1'b0; BUS = 16'h1234; LD_MDR = 1'b1; Mem_req = 1'b1; Mem_rw = 1'b1;
    tick();
    clear_inputs(); BUS = 16'hDEAD;
    observe(6, 1'b0, 16'h0042, 16'h1234);
    n_checks++; if (we_cnt != 2) $display("FAIL wr_we_cycles: got %0d want 2", we_cnt); else n_pass++;
    n_checks++; if (we_at0 !== 1'b1) $display("FAIL wr_we_setup: got %b want 1", we_at0); else n_pass++;
    n_checks++; if (oe_cnt != 0) $display("FAIL wr_oe: got %0d low cycles want 0", oe_cnt); else n_pass++;
    n_checks++; if (mar_bad != 0) $display("FAIL wr_mar: got %0d bad samples want 0", mar_bad); else n_pass++;
    n_checks++; if (mdr_bad != 0) $display("FAIL wr_data: got %0d bad samples want 0", mdr_bad); else n_pass++;
    n_checks++; if (dts_bad != 0) $display("FAIL wr_dts: got %0d bad samples want 0", dts_bad); else n_pass++;
    n_checks++; if (rdy_idx != 3) $display("FAIL wr_latency: got %0d want 3", rdy_idx); else n_pass++;
  endtask

  task automatic test_ld_ignored();
    BUS = 16'h0100; Data_from_SRAM = 16'hA5A5;
    LD_MAR = 1'b1; Mem_req = 1'b1; Mem_rw = 1'b0;
    tick();
    clear_inputs();
    tick();
    BUS = 16'hFFFF; LD_MAR = 1'b1; LD_MDR = 1'b1;
    tick();
    clear_inputs();
    n_checks++; if (MAR_data !== 16'h0100) $display("FAIL busy_ld_mar: got %h want 0100", MAR_data); else n_pass++;
    tick();
    n_checks++; if (Mem_ready !== 1'b1) $display("FAIL busy_ld_ready: got %b want 1", Mem_ready); else n_pass++;
    n_checks++; if (MDR_data !== 16'hA5A5) $display("FAIL busy_ld_mdr: got %h want a5a5", MDR_data); else n_pass++;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    int gap1, gap2;
    BUS = 16'h2000; Data_from_SRAM = 16'h7777;
    LD_MAR = 1'b1; Mem_req = 1'b1; Mem_rw = 1'b0;
    tick();
    LD_MAR = 1'b0;
    observe(14, 1'b0, 16'h2000, 16'h7777);
    Mem_req = 1'b0;
    gap1 = (rdy_pos.size() > 1) ? rdy_pos[1] - rdy_pos[0] : -1;
    gap2 = (rdy_pos.size() > 2) ? rdy_pos[2] - rdy_pos[1] : -1;
    n_checks++; if (rdy_cnt != 3) $display("FAIL b2b_count: got %0d want 3", rdy_cnt); else n_pass++;
    n_checks++; if (rdy_idx != 3) $display("FAIL b2b_first: got %0d want 3", rdy_idx); else n_pass++;
    n_checks++; if (gap1 != 5) $display("FAIL b2b_gap1: got %0d want 5", gap1); else n_pass++;
    n_checks++; if (gap2 != 5) $display("FAIL b2b_gap2: got %0d want 5", gap2); else n_pass++;
    n_checks++; if (busy_low_cnt != 2) $display("FAIL b2b_idle: got %0d want 2", busy_low_cnt); else n_pass++;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_wc1();
    n_checks++; if (Busy1 !== 1'b0) $display("FAIL wc1_idle: got %b want 0", Busy1); else n_pass++;
    BUS = 16'h0777; Data_from_SRAM = 16'h1357;
    LD_MAR = 1'b1; Mem_req = 1'b1; Mem_rw = 1'b0;
    tick();
    clear_inputs();
    observe(5, 1'b1, 16'h0777, 16'h0000);
    n_checks++; if (rdy_idx != 2) $display("FAIL wc1_latency: got %0d want 2", rdy_idx); else n_pass++;
    n_checks++; if (oe_cnt != 2) $display("FAIL wc1_oe_cycles: got %0d want 2", oe_cnt); else n_pass++;
    n_checks++; if (mdr_at_rdy !== 16'h1357) $display("FAIL wc1_mdr: got %h want 1357", mdr_at_rdy); else n_pass++;
    n_checks++; if (rdy_cnt != 1) $display("FAIL wc1_ready_width: got %0d want 1", rdy_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_ld_ignored();
    test_back_to_back();
    test_wc1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
